// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

    typedef enum logic [1:0] {NSA_IDLE, NSA_RUN, NSA_DONE} nsa_state_t;

    localparam int NSA_NIBBLE_W = 4;

endpackage

// File: rtl/nsa_nibble_slice.sv
// Full-adder cell and the 4-bit ripple-carry slice built from it (combinational).

module nsa_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module nsa_nibble_slice
    import nsa_pkg::*;
(
    input  logic [NSA_NIBBLE_W-1:0] a,
    input  logic [NSA_NIBBLE_W-1:0] b,
    input  logic                    carry_in,
    output logic [NSA_NIBBLE_W-1:0] sum,
    output logic                    carry_out,
    output logic                    carry_into_bit3
);
    logic [NSA_NIBBLE_W:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < NSA_NIBBLE_W; i++) begin : g_fa
        nsa_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign carry_out       = c[NSA_NIBBLE_W];
    assign carry_into_bit3 = c[NSA_NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, LSB first.
// Optional subtract path enabled by defining NSA_SUBTRACT_EN.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / NSA_NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    nsa_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;
`ifdef NSA_SUBTRACT_EN
    logic                    sub_q;
`endif

    logic [NSA_NIBBLE_W-1:0] a_nib;
    logic [NSA_NIBBLE_W-1:0] b_nib;
    logic [NSA_NIBBLE_W-1:0] s_nib;
    logic                    s_co;
    logic                    s_c3;

    // Constant-index mux keeps the nibble select free of variable part-selects.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_q[i*NSA_NIBBLE_W +: NSA_NIBBLE_W];
                b_nib = b_q[i*NSA_NIBBLE_W +: NSA_NIBBLE_W];
            end
        end
`ifdef NSA_SUBTRACT_EN
        b_nib = b_nib ^ {NSA_NIBBLE_W{sub_q}};
`endif
    end

    nsa_nibble_slice u_slice (
        .a               (a_nib),
        .b               (b_nib),
        .carry_in        (carry),
        .sum             (s_nib),
        .carry_out       (s_co),
        .carry_into_bit3 (s_c3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= NSA_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef NSA_SUBTRACT_EN
            sub_q     <= 1'b0;
`endif
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                NSA_IDLE: begin
                    if (op_valid && op_ready) begin
                        state    <= NSA_RUN;
                        a_q      <= a;
                        b_q      <= b;
                        idx      <= '0;
`ifdef NSA_SUBTRACT_EN
                        sub_q    <= sub;
                        carry    <= sub ? 1'b1 : c_in;
`else
                        carry    <= c_in;
`endif
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                NSA_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i))
                            sum[i*NSA_NIBBLE_W +: NSA_NIBBLE_W] <= s_nib;
                    end
                    carry <= s_co;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        state     <= NSA_DONE;
                        idx       <= '0;
                        res_valid <= 1'b1;
                        c_out     <= s_co;
                        ovf       <= s_co ^ s_c3;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                NSA_DONE: begin
                    if (res_ready) begin
                        state     <= NSA_IDLE;
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= NSA_IDLE;
            endcase
        end
    end
endmodule
